// File: rtl/csa_resolver.sv
// csa_resolver: resolves a carry-save pair (ps, pc) into sum = ps + 2*pc mod 2^N.
// Ports: clk, rst_n, in_valid/in_ready/ps_i/pc_i, out_valid/out_ready/sum_o, busy.
// Optional macro CSA_RESOLVER_OVF_EN adds ovf_o (true sum >= 2^N).
module csa_resolver #(
  parameter int N     = 32,
  parameter int CHUNK = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] ps_i,
  input  logic [N-1:0] pc_i,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum_o,
  output logic         busy
`ifdef CSA_RESOLVER_OVF_EN
  ,
  output logic         ovf_o
`endif
);

  localparam int NCH = N / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int AW  = N - CHUNK;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          carry_q, carry_d;
  logic [N-1:0]  a_q, a_d;
  logic [N-1:0]  b_q, b_d;
  logic [AW-1:0] acc_q, acc_d;
  logic [N-1:0]  sum_q, sum_d;
  logic [CHUNK:0] res;
  logic          accept;
  logic          last;

`ifdef CSA_RESOLVER_OVF_EN
  logic pcm_q, pcm_d;
  logic ovf_q, ovf_d;
  assign ovf_o = ovf_q;
`else
  logic unused_pc_msb;
  assign unused_pc_msb = pc_i[N-1];
`endif

  assign in_ready  = (state_q == S_IDLE) ||
                     ((state_q == S_DONE) && out_ready);
  assign out_valid = (state_q == S_DONE);
  assign busy      = (state_q != S_IDLE);
  assign sum_o     = sum_q;
  assign accept    = in_valid && in_ready;
  assign last      = (cnt_q == CW'(NCH - 1));

  // Operands shift right one chunk per cycle, so the adder
  // always works on the low chunk; results shift in from the top.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    sum_d   = sum_q;
`ifdef CSA_RESOLVER_OVF_EN
    pcm_d   = pcm_q;
    ovf_d   = ovf_q;
`endif
    res = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} +
          {{CHUNK{1'b0}}, carry_q};
    unique case (state_q)
      S_IDLE: ;
      S_ADD: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        acc_d   = AW'({res[CHUNK-1:0], acc_q} >> CHUNK);
        carry_d = res[CHUNK];
        cnt_d   = cnt_q + CW'(1);
        if (last) begin
          state_d = S_DONE;
          sum_d   = {res[CHUNK-1:0], acc_q};
`ifdef CSA_RESOLVER_OVF_EN
          ovf_d   = res[CHUNK] | pcm_q;
`endif
        end
      end
      S_DONE: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) begin
      state_d = S_ADD;
      a_d     = ps_i;
      b_d     = {pc_i[N-2:0], 1'b0};
      cnt_d   = '0;
      carry_d = 1'b0;
`ifdef CSA_RESOLVER_OVF_EN
      pcm_d   = pc_i[N-1];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
`ifdef CSA_RESOLVER_OVF_EN
      pcm_q   <= 1'b0;
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
`ifdef CSA_RESOLVER_OVF_EN
      pcm_q   <= pcm_d;
      ovf_q   <= ovf_d;
`endif
    end
  end

endmodule
